// File: rtl/sipo_frame_controller_pkg.sv
// Shared definitions for the serial frame receiver: state encodings, frame length and
// the parity helper used when a parity bit follows the data bits.
package sipo_frame_controller_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Parity bit the transmitter must send for this byte.
  function automatic logic parity_expected(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sipo_shift_en.sv
// Serial-in/parallel-out register: on shift_en, shifts right with the new bit entering the MSB,
// so an LSB-first stream ends up in natural bit order.
module sipo_shift_en
  import sipo_frame_controller_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] data
);

  logic [DATA_BITS-1:0] data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (shift_en) begin
      data_q <= {bit_in, data_q[DATA_BITS-1:1]};
    end
  end

  assign data = data_q;

endmodule

// File: rtl/sipo_frame_controller.sv
// Receives one serial frame (start, 8 data bits LSB first, optional parity, stop) and hands
// the byte to the decoder on a valid/ready handshake, flagging framing/parity/overrun faults.
module sipo_frame_controller
  import sipo_frame_controller_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serialIn,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 dataValid,
  input  logic                 dataReady,
  output logic                 busy,
  output logic                 frameError,
  output logic                 parityError,
  output logic                 overrun
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] SampleMid = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] SampleEnd = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastBit   = BitW'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [CntW-1:0]      clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 parity_bad_q, parity_bad_d;
  logic [1:0]           sync_q;
  logic [1:0]           fill_q;
  logic                 line_high_q;
  logic                 line;
  logic                 fall;
  logic                 shift_en;
  logic                 stop_sample;
  logic [DATA_BITS-1:0] sipo_data;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 data_valid_q;
  logic                 frame_err_q;
  logic                 parity_err_q;
  logic                 overrun_q;
  logic                 frame_ok;
  logic                 accept;
  logic                 load;

  // fill_q marks when the synchroniser holds real samples rather than its reset value, so a
  // line already low when reset is released is not mistaken for a start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q      <= 2'b11;
      fill_q      <= 2'b00;
      line_high_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], serialIn};
      fill_q      <= {fill_q[0], 1'b1};
      line_high_q <= fill_q[1] & line;
    end
  end

  assign line = sync_q[1];
  assign fall = line_high_q & ~line;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      parity_bad_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      parity_bad_q <= parity_bad_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q + CntW'(1);
    bit_cnt_d    = bit_cnt_q;
    parity_bad_d = parity_bad_q;
    shift_en     = 1'b0;
    stop_sample  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (fall) state_d = ST_START;
      end
      ST_START: begin
        if (clk_cnt_q == SampleMid) begin
          clk_cnt_d = '0;
          if (line) begin
            state_d = ST_IDLE;
          end else begin
            state_d      = ST_DATA;
            bit_cnt_d    = '0;
            parity_bad_d = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == SampleEnd) begin
          clk_cnt_d = '0;
          shift_en  = 1'b1;
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (clk_cnt_q == SampleEnd) begin
          clk_cnt_d    = '0;
          parity_bad_d = line != parity_expected(sipo_data, PARITY_ODD != 0);
          state_d      = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == SampleEnd) begin
          clk_cnt_d   = '0;
          stop_sample = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  sipo_shift_en u_sipo (
    .clock    (clock),
    .reset    (reset),
    .shift_en (shift_en),
    .bit_in   (line),
    .data     (sipo_data)
  );

  // A load in the same cycle as an accept wins: the fresh byte replaces the consumed one.
  assign frame_ok = stop_sample & line & ~parity_bad_q;
  assign accept   = data_valid_q & dataReady;
  assign load     = frame_ok & (~data_valid_q | accept);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q  <= stop_sample & ~line;
      parity_err_q <= stop_sample & line & parity_bad_q;
      overrun_q    <= frame_ok & data_valid_q & ~accept;
      if (load) begin
        data_out_q   <= sipo_data;
        data_valid_q <= 1'b1;
      end else if (accept) begin
        data_valid_q <= 1'b0;
      end
    end
  end

  assign dataOut     = data_out_q;
  assign dataValid   = data_valid_q;
  assign busy        = state_q != ST_IDLE;
  assign frameError  = frame_err_q;
  assign parityError = parity_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sipo_frame_controller.sv
// Bench for sipo_frame_controller: a frame-level model predicts each frame's outcome and when
// it appears, a per-cycle compare checks both DUTs (no parity / even parity) against it.
module tb_sipo_frame_controller;
  import sipo_frame_controller_pkg::*;

  localparam int unsigned CPB  = 4;
  localparam int unsigned HALF = CPB / 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       ser0, ser1, rdy0, rdy1;
  logic [7:0] dout0, dout1;
  logic       dval0, dval1, busy0, busy1, fe0, fe1, pe0, pe1, ov0, ov1;

  always #5 clock = ~clock;

  sipo_frame_controller #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clock(clock), .reset(reset), .serialIn(ser0), .dataOut(dout0), .dataValid(dval0),
    .dataReady(rdy0), .busy(busy0), .frameError(fe0), .parityError(pe0), .overrun(ov0)
  );

  sipo_frame_controller #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clock(clock), .reset(reset), .serialIn(ser1), .dataOut(dout1), .dataValid(dval1),
    .dataReady(rdy1), .busy(busy1), .frameError(fe1), .parityError(pe1), .overrun(ov1)
  );

  // Frame outcomes: 0 good byte, 1 framing error, 2 parity error.
  typedef struct {
    int         inst;
    int         cyc;
    int         kind;
    logic [7:0] b;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         fe_seen[2] = '{default: 0};
  int         pe_seen[2] = '{default: 0};
  int         ov_seen[2] = '{default: 0};
  logic [7:0] m_dout[2] = '{default: 8'h00};
  logic       m_valid[2] = '{default: 1'b0};
  logic       m_acc[2] = '{default: 1'b0};

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge clock) begin
    logic [7:0] a_do[2];
    logic       a_dv[2], a_fe[2], a_pe[2], a_ov[2], a_rdy[2];
    logic       e_fe, e_pe, e_ov, ld, acc;
    a_do[0] = dout0; a_dv[0] = dval0; a_fe[0] = fe0; a_pe[0] = pe0; a_ov[0] = ov0; a_rdy[0] = rdy0;
    a_do[1] = dout1; a_dv[1] = dval1; a_fe[1] = fe1; a_pe[1] = pe1; a_ov[1] = ov1; a_rdy[1] = rdy1;
    if (reset) begin
      evq.delete();
      for (int i = 0; i < 2; i++) begin
        m_dout[i] = 8'h00; m_valid[i] = 1'b0; m_acc[i] = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      e_fe = 1'b0; e_pe = 1'b0; e_ov = 1'b0; ld = 1'b0; acc = m_acc[i];
      if (!reset) begin
        for (int j = 0; j < evq.size(); j++) begin
          if (evq[j].inst == i && evq[j].cyc == cyc) begin
            if (evq[j].kind == 1) e_fe = 1'b1;
            else if (evq[j].kind == 2) e_pe = 1'b1;
            else if (!m_valid[i] || acc) begin ld = 1'b1; m_dout[i] = evq[j].b; end
            else e_ov = 1'b1;
          end
        end
        if (ld) m_valid[i] = 1'b1;
        else if (acc) m_valid[i] = 1'b0;
      end
      check($sformatf("dut%0d dataValid", i), a_dv[i], m_valid[i]);
      if (m_valid[i] || reset) check($sformatf("dut%0d dataOut", i), a_do[i], m_dout[i]);
      check($sformatf("dut%0d frameError", i), a_fe[i], e_fe);
      check($sformatf("dut%0d parityError", i), a_pe[i], e_pe);
      check($sformatf("dut%0d overrun", i), a_ov[i], e_ov);
      fe_seen[i] += int'(a_fe[i]);
      pe_seen[i] += int'(a_pe[i]);
      ov_seen[i] += int'(a_ov[i]);
      m_acc[i] = m_valid[i] & a_rdy[i];
    end
    while (evq.size() > 0 && evq[0].cyc <= cyc) void'(evq.pop_front());
  end

  task automatic drive(input int inst, input logic v);
    if (inst == 0) ser0 = v;
    else ser1 = v;
  endtask

  task automatic hold_bit(input int inst, input logic v);
    drive(inst, v);
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  // Outcome lands CPB*(bits after start) + HALF + 3 edges after the start bit is driven:
  // two synchroniser stages plus the edge-detect register precede the START state.
  task automatic send_frame(input int inst, input logic [7:0] b, input logic par, input logic stop);
    int p;
    int kind;
    p = (inst == 1) ? 1 : 0;
    @(posedge clock);
    #1;
    if (!stop) kind = 1;
    else if (p == 1 && par != ^b) kind = 2;
    else kind = 0;
    evq.push_back('{inst: inst, cyc: cyc + 3 + int'(HALF) + int'(CPB) * (int'(DATA_BITS) + 1 + p),
                   kind: kind, b: b});
    hold_bit(inst, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(inst, b[i]);
    if (p == 1) hold_bit(inst, par);
    hold_bit(inst, stop);
    drive(inst, 1'b1);
  endtask

  task automatic wait_valid(input int inst, input logic [7:0] exp_b, input string name);
    logic v;
    logic [7:0] d;
    v = 1'b0;
    d = 8'h00;
    for (int n = 0; n < 64; n++) begin
      @(negedge clock);
      v = (inst == 0) ? dval0 : dval1;
      d = (inst == 0) ? dout0 : dout1;
      if (v) break;
    end
    check({name, " valid"}, v, 1'b1);
    check({name, " byte"}, d, exp_b);
  endtask

  initial begin
    reset = 1'b1;
    ser0 = 1'b1; ser1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset dataValid", dval0, 1'b0);
    check("reset dataOut", dout0, 8'h00);
    check("reset busy", busy0, 1'b0);
    repeat (4) @(posedge clock);

    // 1: plain frame, consumer ready
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    wait_valid(0, 8'hA5, "t1");
    @(negedge clock);
    check("t1 valid one cycle", dval0, 1'b0);

    // 2: start glitch
    @(posedge clock); #1 ser0 = 1'b0;
    @(posedge clock); #1 ser0 = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    check("t2 busy after glitch", busy0, 1'b0);
    check("t2 no valid", dval0, 1'b0);

    // 3: stop bit low, then recovery
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("t3 frameError count", fe_seen[0], 1);
    check("t3 no valid", dval0, 1'b0);
    send_frame(0, 8'h55, 1'b0, 1'b1);
    wait_valid(0, 8'h55, "t3 recovery");

    // 4: even parity, 0x07 needs parity bit 1
    send_frame(1, 8'h07, 1'b0, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    check("t4 parityError count", pe_seen[1], 1);
    send_frame(1, 8'h07, 1'b1, 1'b1);
    wait_valid(1, 8'h07, "t4 good parity");

    // 5: overrun while consumer stalls
    @(posedge clock); #1 rdy0 = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b1);
    wait_valid(0, 8'h11, "t5 first");
    send_frame(0, 8'h22, 1'b0, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    check("t5 overrun count", ov_seen[0], 1);
    check("t5 old byte kept", dout0, 8'h11);
    check("t5 still valid", dval0, 1'b1);
    rdy0 = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("t5 drained", dval0, 1'b0);

    // 6: reset mid-DATA of 0xFF
    @(posedge clock); #1 ser0 = 1'b0;
    repeat (CPB) @(posedge clock);
    #1 ser0 = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("t6 busy mid-frame", busy0, 1'b1);
    reset = 1'b1;
    #1;
    check("t6 busy after reset", busy0, 1'b0);
    check("t6 dataOut after reset", dout0, 8'h00);
    check("t6 dut1 dataOut after reset", dout1, 8'h00);
    check("t6 dataValid after reset", dval0, 1'b0);
    check("t6 errors after reset", {fe0, pe0, ov0}, 3'b000);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(posedge clock);
    send_frame(0, 8'h81, 1'b0, 1'b1);
    wait_valid(0, 8'h81, "t6 after reset");
    check("fe total dut0", fe_seen[0], 1);
    check("pe total dut1", pe_seen[1], 1);

    repeat (5) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
